board_level_data_block_receiver: RTL and testbench
==================================================

// Module: board_level_data_block_receiver
// PURPOSE
//  Receive-side block layer of the board-level serial link. Sits above the byte-level receiver.
//  Rebuilds fixed-size BYTE_N-byte blocks from a start/data/end byte stream, checks frame length
//  and presents each complete block on a valid/ack output register. Block byte order: the first
//  received byte lands in data[7:0].
// PARAMETERS
//  BYTE_N          8     bytes per block; legal range >= 1; DATA_W = BYTE_N*8
//  TIMEOUT_CYCLES  1024  idle clk cycles inside a frame before abort (only with macro)
// PORTS
//  clk             in   1        system clock
//  rst             in   1        synchronous, active-high reset
//  in_valid        in   1        one beat from the byte-level receiver this cycle
//  in_frame_start  in   1        beat is a frame-start marker (in_data ignored)
//  in_frame_end    in   1        beat is a frame-end marker (in_data ignored)
//  in_data         in   8        payload byte when in_valid and neither marker is set
//  data            out  DATA_W   assembled block; stable while data_valid=1
//  data_valid      out  1        block available; held until acknowledged
//  data_ack        in   1        consumer takes the block; effective only while data_valid=1
//  err_short       out  1        1-cycle pulse: end marker received before BYTE_N bytes
//  err_long        out  1        1-cycle pulse: data byte received after BYTE_N bytes
//  err_overrun     out  1        1-cycle pulse: completed block dropped, output still full
//  err_timeout     out  1        1-cycle pulse: frame aborted on idle timeout (0 without macro)
// BEHAVIOUR
//  Reset values: data=0, data_valid=0, all err_*=0, FSM=IDLE, byte counter=0, timeout counter=0.
//  Beat decode applies only when in_valid=1; in_valid=0 is a no-op.
//   Marker priority: start > end > data.
//  FSM states:
//   IDLE      start -> RECV, clear counter. end and data beats are discarded silently.
//   RECV      data  -> shift in, cnt+1; at cnt+1 == BYTE_N go to WAIT_END.
//             end   -> err_short, go to IDLE.
//             start -> restart: stay in RECV, clear counter, discard partial block, no error.
//   WAIT_END  end   -> commit, go to IDLE.
//             data  -> err_long, go to IDLE; remaining bytes are discarded until the next start.
//             start -> restart into RECV, counter=0.
//  Shift register: sreg <= {in_data, sreg[DATA_W-1:8]}. After BYTE_N bytes the first byte is in
//   [7:0]. For BYTE_N=1 this is a direct load.
//  Counter width is clog2(BYTE_N)+1; it never exceeds BYTE_N and cannot wrap.
//  Commit latency: the end marker accepted on clock edge N gives data/data_valid updated on edge N
//   (visible in the cycle after the end beat).
//  Output handshake, evaluated on the commit edge:
//   data_valid=0                        -> load data, set data_valid=1.
//   data_valid=1 and data_ack=1         -> load new data, data_valid stays 1 (no bubble).
//   data_valid=1 and data_ack=0         -> drop new block, data unchanged, err_overrun.
//  Ack without a commit: data_valid clears on the next edge; data keeps its last value.
//   data_ack while data_valid=0 is ignored.
//  The receive FSM never stalls on the output side (there is no input backpressure).
//  Error pulses are registered and are high for exactly 1 cycle. Several may assert in the same
//   cycle only via err_overrun, which is independent of the FSM errors.
//  Reset mid-frame: the partial block is lost; data_valid=0; the next frame needs a fresh start.
// CONFIGURATION
//  BOARD_LEVEL_BLOCK_RX_TIMEOUT_EN defined:
//   - A timeout counter runs in RECV/WAIT_END and clears on every in_valid beat.
//   - On reaching TIMEOUT_CYCLES: err_timeout pulse, FSM -> IDLE, partial block discarded.
//   - In IDLE the counter is held at 0.
//  Not defined: no timeout counter logic; err_timeout is tied to 0; a frame waits indefinitely.
// TESTING (BYTE_N=4)
//  1. start,11,22,33,44,end -> data=32'h44332211, data_valid=1 the cycle after end; ack clears it.
//  2. start,11,22,end -> err_short pulse, data_valid stays 0; then a good frame AA..DD gives
//     32'hDDCCBBAA.
//  3. start,11,22,33,44,55,end -> err_long on 55, no commit; then a good frame is accepted.
//  4. Two good frames, no ack -> second dropped, err_overrun, data=first block. Repeat with
//     data_ack on the commit cycle -> data=second block, data_valid stays 1.
//  5. start,11,22,start,AA,BB,CC,DD,end -> 32'hDDCCBBAA, no errors. rst asserted after 2 bytes ->
//     all outputs 0; the following frame is good.
//  6. Macro on, TIMEOUT_CYCLES=16: start,11, then 16 idle cycles -> err_timeout, IDLE; with the
//     macro off -> no pulse and the frame later completes normally.

Source files
------------

// File: rtl/board_level_data_block_receiver.sv
// Receive-side block layer of the board-level serial link.
// Rebuilds BYTE_N-byte blocks from a start/data/end beat stream, checks frame
// length and presents each complete block on a valid/ack output register.
// The first received byte lands in data[7:0].
// Optional idle timeout: define BOARD_LEVEL_BLOCK_RX_TIMEOUT_EN.
module board_level_data_block_receiver #(
    parameter int BYTE_N         = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                in_frame_start,
    input  logic                in_frame_end,
    input  logic [7:0]          in_data,
    output logic [BYTE_N*8-1:0] data,
    output logic                data_valid,
    input  logic                data_ack,
    output logic                err_short,
    output logic                err_long,
    output logic                err_overrun,
    output logic                err_timeout
);

    localparam int DATA_W = BYTE_N * 8;
    localparam int CNT_W  = $clog2(BYTE_N) + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RECV     = 2'd1,
        WAIT_END = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  sreg;
    logic [DATA_W-1:0]  sreg_next;
    logic               beat_start;
    logic               beat_end;
    logic               beat_data;
    logic               commit;
    logic               timeout_hit;

    // Illegal configurations leave an empty marker scope; nothing else depends on it.
    if (BYTE_N < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    end

    // Marker priority: start beats end beats data; nothing happens without in_valid.
    assign beat_start = in_valid & in_frame_start;
    assign beat_end   = in_valid & ~in_frame_start & in_frame_end;
    assign beat_data  = in_valid & ~in_frame_start & ~in_frame_end;

    // A block is committed only by an end marker after exactly BYTE_N bytes.
    assign commit = (state == WAIT_END) && beat_end;

    // New bytes enter at the top so the first byte ends up in [7:0].
    if (BYTE_N == 1) begin : g_single
        assign sreg_next = in_data;
    end else begin : g_multi
        assign sreg_next = {in_data, sreg[DATA_W-1:8]};
    end

`ifdef BOARD_LEVEL_BLOCK_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;

    assign timeout_hit = (state != IDLE) && !in_valid &&
                         (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Count idle cycles inside a frame; any beat or leaving the frame restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= timeout_hit;
            if (state == IDLE || in_valid || timeout_hit)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Frame FSM: tracks start/data/end beats and raises the length errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
        end else begin
            err_short <= 1'b0;
            err_long  <= 1'b0;
            case (state)
                IDLE: begin
                    if (beat_start) begin
                        state <= RECV;
                        cnt   <= '0;
                    end
                end
                RECV: begin
                    if (beat_start) begin
                        cnt <= '0;
                    end else if (beat_end) begin
                        err_short <= 1'b1;
                        state     <= IDLE;
                    end else if (beat_data) begin
                        sreg <= sreg_next;
                        cnt  <= cnt + 1'b1;
                        if (cnt == CNT_W'(BYTE_N - 1))
                            state <= WAIT_END;
                    end
                end
                WAIT_END: begin
                    if (beat_start) begin
                        state <= RECV;
                        cnt   <= '0;
                    end else if (beat_end) begin
                        state <= IDLE;
                    end else if (beat_data) begin
                        err_long <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (timeout_hit)
                state <= IDLE;
        end
    end

    // Output register: load on commit when empty or being acked, else drop and flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            data        <= '0;
            data_valid  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_overrun <= 1'b0;
            if (commit) begin
                if (!data_valid || data_ack) begin
                    data       <= sreg;
                    data_valid <= 1'b1;
                end else begin
                    err_overrun <= 1'b1;
                end
            end else if (data_valid && data_ack) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_board_level_data_block_receiver.sv
// Scoreboard bench for board_level_data_block_receiver with BYTE_N=4.
// The reference model works on byte queues per frame; expected per-cycle
// flags and expected blocks are queued and checked by a separate monitor.
module tb_board_level_data_block_receiver;

    localparam int N  = 4;
    localparam int DW = N * 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_frame_start = 1'b0;
    logic          in_frame_end = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          data_ack = 1'b0;
    logic [DW-1:0] data;
    logic          data_valid;
    logic          err_short;
    logic          err_long;
    logic          err_overrun;
    logic          err_timeout;

    always #5 clk = ~clk;

    board_level_data_block_receiver #(
        .BYTE_N         (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_frame_start (in_frame_start),
        .in_frame_end   (in_frame_end),
        .in_data        (in_data),
        .data           (data),
        .data_valid     (data_valid),
        .data_ack       (data_ack),
        .err_short      (err_short),
        .err_long       (err_long),
        .err_overrun    (err_overrun),
        .err_timeout    (err_timeout)
    );

    typedef struct packed {
        logic vld;
        logic es;
        logic el;
        logic eo;
        logic et;
    } exp_t;

    exp_t          exp_cyc[$];
    logic [DW-1:0] exp_blk[$];
    int            errors = 0;
    int            checks = 0;

    // reference model state
    bit            m_collect = 0;
    bit            m_full = 0;
    logic [7:0]    m_frame[$];
    int            m_idle = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    function automatic bit ra();
        return ($urandom % 3) == 0;
    endfunction

    // One clock of stimulus plus the model's view of what that edge produces.
    task automatic step(input bit v, input bit s, input bit e, input logic [7:0] b, input bit ack);
        exp_t          x;
        logic [DW-1:0] blk;
        bit            commit;
        in_valid       = v;
        in_frame_start = s;
        in_frame_end   = e;
        in_data        = b;
        data_ack       = ack;
        x      = '0;
        blk    = '0;
        commit = 0;
`ifdef BOARD_LEVEL_BLOCK_RX_TIMEOUT_EN
        if (m_collect && !v) begin
            m_idle++;
            if (m_idle == TO) begin
                x.et      = 1'b1;
                m_collect = 0;
                m_idle    = 0;
            end
        end else begin
            m_idle = 0;
        end
`endif
        if (v) begin
            if (s) begin
                m_frame.delete();
                m_collect = 1;
            end else if (e) begin
                if (m_collect) begin
                    if (m_frame.size() == N) begin
                        commit = 1;
                        for (int i = 0; i < N; i++) blk[8*i +: 8] = m_frame[i];
                    end else begin
                        x.es = 1'b1;
                    end
                end
                m_collect = 0;
            end else if (m_collect) begin
                if (m_frame.size() < N) begin
                    m_frame.push_back(b);
                end else begin
                    x.el      = 1'b1;
                    m_collect = 0;
                end
            end
        end
        if (commit) begin
            if (m_full && !ack) begin
                x.eo   = 1'b1;
                commit = 0;
            end else begin
                m_full = 1;
            end
        end else if (m_full && ack) begin
            m_full = 0;
        end
        x.vld = m_full;
        @(posedge clk);
        #1;
        if (commit) exp_blk.push_back(blk);
        exp_cyc.push_back(x);
    endtask

    task automatic st(input bit ack);
        step(1, 1, 1'($urandom % 2), 8'($urandom), ack);
    endtask

    task automatic en(input bit ack);
        step(1, 0, 1, 8'($urandom), ack);
    endtask

    task automatic dt(input logic [7:0] b, input bit ack);
        step(1, 0, 0, b, ack);
    endtask

    // ackmode: 0 never, 1 always, 2 random; markers toggle freely while in_valid=0
    task automatic idl(input int n, input int ackmode);
        for (int i = 0; i < n; i++)
            step(0, 1'($urandom % 2), 1'($urandom % 2), 8'($urandom),
                 ackmode == 2 ? ra() : (ackmode == 1));
    endtask

    task automatic good(input logic [DW-1:0] blk, input bit ack_end);
        st(0);
        for (int i = 0; i < N; i++) dt(blk[8*i +: 8], 0);
        en(ack_end);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        data_ack = 1'b0;
        m_collect = 0;
        m_full    = 0;
        m_idle    = 0;
        m_frame.delete();
        @(posedge clk);
        #1;
        exp_blk.delete();
        exp_cyc.push_back('0);
        rst = 1'b0;
    endtask

    // Monitor: per-cycle flags, plus every block the consumer takes.
    always @(negedge clk) begin
        exp_t x;
        if (exp_cyc.size() > 0) begin
            x = exp_cyc.pop_front();
            chk("data_valid",  DW'(data_valid),  DW'(x.vld));
            chk("err_short",   DW'(err_short),   DW'(x.es));
            chk("err_long",    DW'(err_long),    DW'(x.el));
            chk("err_overrun", DW'(err_overrun), DW'(x.eo));
            chk("err_timeout", DW'(err_timeout), DW'(x.et));
        end
        if (!rst && data_valid && data_ack) begin
            if (exp_blk.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL block at %0t: got %h expected no block", $time, data);
            end else begin
                chk("block", data, exp_blk.pop_front());
            end
        end
    end

    initial begin
        do_reset();
        chk("reset_data", data, '0);

        // clean frame, then ack
        good(32'h44332211, 0);
        idl(1, 1);
        idl(2, 0);

        // short frame, then good frame
        st(0); dt(8'h11, 0); dt(8'h22, 0); en(0);
        good(32'hDDCCBBAA, 0);
        idl(1, 1);

        // long frame: error on fifth byte, trailing end discarded
        st(0);
        for (int i = 1; i <= 5; i++) dt(8'(8'h11 * i), 0);
        en(0);
        dt(8'h99, 0);
        good(32'h0D0C0B0A, 0);
        idl(1, 1);

        // overrun: second block dropped, first retained
        good(32'h01020304, 0);
        good(32'h05060708, 0);
        idl(2, 0);
        idl(1, 1);
        // ack on the commit cycle replaces the block without a bubble
        good(32'h11121314, 0);
        good(32'h21222324, 1);
        idl(1, 0);
        idl(1, 1);

        // restart mid-frame
        st(0); dt(8'h11, 0); dt(8'h22, 0);
        good(32'hDDCCBBAA, 0);
        idl(1, 1);

        // reset mid-frame with a pending block
        good(32'hCAFEF00D, 0);
        st(0); dt(8'h11, 0); dt(8'h22, 0);
        do_reset();
        chk("reset_mid_data", data, '0);
        dt(8'h33, 0); dt(8'h44, 0); en(0);
        good(32'h87654321, 0);
        idl(1, 1);

        // long idle inside a frame
        st(0); dt(8'h11, 0);
        idl(TO + 4, 0);
        dt(8'h22, 0); dt(8'h33, 0); dt(8'h44, 0); en(0);
        idl(1, 1);
        idl(1, 0);

        // randomized frames
        for (int f = 0; f < 300; f++) begin
            int len;
            len = $urandom_range(6, 0);
            if ($urandom % 4 != 0) len = N;
            if ($urandom % 40 == 0) do_reset();
            if ($urandom % 8 != 0) st(ra());
            for (int i = 0; i < len; i++) begin
                idl($urandom_range(2, 0), 2);
                if ($urandom % 20 == 0) st(ra());
                dt(8'($urandom), ra());
            end
            if ($urandom % 8 != 0) en(ra());
            idl($urandom_range(3, 0), 2);
        end

        // drain
        idl(3, 1);
        @(negedge clk);
        #1;
        chk("drain", DW'(exp_blk.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
